me_sad_search: RTL and testbench
================================

ME_SAD_SEARCH -- requirements
Module: me_sad_search

Interface
REQ-001 Parameter PIX, default 4, pixels per memory word (power of 2, >=1).
REQ-002 Parameter PW, default 8, bits per pixel.
REQ-003 Parameter BLK, default 16, template block side in pixels (multiple of PIX).
REQ-004 Parameter RANGE, default 16, candidate positions per axis (power of 2); search window side SWW = BLK+RANGE-1.
REQ-005 Derived: SADW = PW+clog2(BLK*BLK); MVW = clog2(RANGE); SWA = clog2(SWW*SWW); TBA = clog2(BLK*BLK/PIX).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req  in  1  start request, level, held high until ack seen.
REQ-010 et_en  in  1  early-termination enable, sampled at start.
REQ-011 ack  out  1  search complete, results valid.
REQ-012 min_sad  out  SADW  minimum SAD found.
REQ-013 min_mvec  out  2*MVW  {h,w} offset of minimum, h in upper half.
REQ-014 addr_sw  out  SWA  search-window pixel address, (row*SWW + col).
REQ-015 pel_sw  in  PIX*PW  PIX consecutive pixels from addr_sw, lane 0 in LSBs, one-cycle read latency, unaligned access supported by memory.
REQ-016 addr_tb  out  TBA  template word address, (row*BLK/PIX + colword).
REQ-017 pel_tb  in  PIX*PW  template word, lane 0 in LSBs, one-cycle read latency.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; IDLE->RUN when req=1; RUN->DRAIN after last read issued; DRAIN->DONE after final accumulate and compare; DONE->IDLE when req=0.
REQ-019 Candidates scanned raster order, h outer 0..RANGE-1, w inner 0..RANGE-1; within candidate, rows outer, words inner.
REQ-020 RUN issues one addr_sw/addr_tb pair per cycle: addr_sw = (h+row)*SWW + w + colword*PIX, addr_tb = row*(BLK/PIX)+colword.
REQ-021 Per returned word: sum of PIX lane |sw-tb| added to candidate accumulator, unsigned, SADW bits, no overflow possible.
REQ-022 Candidate end: first candidate always loads min; later candidates replace min only if accumulator strictly less (earliest raster minimum wins ties).
REQ-023 With et_en=1: when accumulator after any add is >= current min (not first candidate), candidate aborted, in-flight read discarded, address generation jumps to next candidate's first word next cycle.
REQ-024 With et_en=0: ack rises exactly RANGE*RANGE*BLK*BLK/PIX + 3 clk edges after the edge sampling req=1 in IDLE.
REQ-025 ack high only in DONE; held while req=1; if req already 0 on DONE entry, ack high one cycle.
REQ-026 min_sad/min_mvec stable from DONE entry until next IDLE->RUN; cleared to 0 on RUN entry.
REQ-027 req changes during RUN/DRAIN ignored; et_en changes after start ignored.
REQ-028 addr_sw/addr_tb drive 0 outside RUN.

Reset
REQ-029 rst=1 at any edge, including mid-RUN: state IDLE, ack=0, min_sad=0, min_mvec=0, addresses 0, accumulator and counters 0; pending reads discarded.
REQ-030 After rst release, new search requires req sampled high in IDLE.

Structure
REQ-031 Shared package me_pkg: state encodings, clog2-derived width functions, default parameter values.
REQ-032 One sub-module me_sad_tree: combinational PIX-lane absolute-difference adder tree, output PW+clog2(PIX) bits.

Verification
REQ-033 Defaults, window = template embedded at (h=3,w=5), elsewhere pixels 255 vs template 0 -> min_sad=0, min_mvec h=3 w=5, ack at 16387 cycles after req.
REQ-034 Defaults, sw and tb all zero -> min_sad=0, min_mvec=(0,0) (tie-break), ack at 16387 cycles.
REQ-035 Defaults, tb all 1, sw all 0 -> min_sad=256, min_mvec=(0,0).
REQ-036 REQ-033 data with et_en=1 -> identical min_sad/min_mvec, ack strictly earlier than 16387 cycles.
REQ-037 rst asserted 100 cycles into RUN, then req held -> outputs 0 during reset, fresh search completes with REQ-033 results at full latency.
REQ-038 PIX=1, BLK=4, RANGE=4, random data -> min_sad/min_mvec match software model; req dropped 1 cycle after ack -> ack low next cycle, return to IDLE.

Source files
------------

// File: rtl/me_pkg.sv
// Shared definitions for the SAD motion-estimation search: state encoding,
// default parameter values and the width helpers that derive port sizes.
package me_pkg;

    localparam int DEF_PIX   = 4;
    localparam int DEF_PW    = 8;
    localparam int DEF_BLK   = 16;
    localparam int DEF_RANGE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } me_state_t;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Accumulated SAD over a whole block can never exceed (2^PW-1)*BLK*BLK.
    function automatic int sad_width(input int pw, input int blk);
        return pw + $clog2(blk * blk);
    endfunction

    function automatic int mv_width(input int range);
        return $clog2(range);
    endfunction

    function automatic int sw_addr_width(input int blk, input int range);
        return $clog2((blk + range - 1) * (blk + range - 1));
    endfunction

    function automatic int tb_addr_width(input int blk, input int pix);
        return $clog2(blk * blk / pix);
    endfunction

    // One word's worth of lane differences summed together.
    function automatic int tree_width(input int pw, input int pix);
        return pw + $clog2(pix);
    endfunction

endpackage

// File: rtl/me_sad_tree.sv
// Combinational absolute-difference adder tree over the PIX lanes of one
// memory word. The tree is laid out heap-style: leaves hold the per-lane
// differences and every inner node adds its two children.
module me_sad_tree
    import me_pkg::*;
#(
    parameter  int PIX = DEF_PIX,
    parameter  int PW  = DEF_PW,
    localparam int OW  = tree_width(PW, PIX)
) (
    input  logic [PIX*PW-1:0] pel_a,
    input  logic [PIX*PW-1:0] pel_b,
    output logic [OW-1:0]     sad
);

    logic [OW-1:0] node [2*PIX-1];
    logic [PW-1:0] lane_a;
    logic [PW-1:0] lane_b;

    // Leaves first, then parents from the bottom of the heap up to the root.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < 2*PIX-1; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < PIX; i++) begin
            lane_a = pel_a[i*PW +: PW];
            lane_b = pel_b[i*PW +: PW];
            node[PIX-1+i] = (lane_a > lane_b) ? OW'(lane_a - lane_b) : OW'(lane_b - lane_a);
        end
        for (int i = PIX-2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    assign sad = node[0];

endmodule

// File: rtl/me_sad_search.sv
// Full-search block matcher. Scans every candidate offset in raster order,
// accumulates the SAD of the template against the search window one memory
// word per cycle, and reports the earliest minimum. Optional early
// termination abandons a candidate as soon as it can no longer win.
//
// Pipeline per word: address issued (cycle k), memory data valid (k+1),
// tree sum registered (edge k+2), accumulate/compare (edge k+3).
module me_sad_search
    import me_pkg::*;
#(
    parameter  int PIX   = DEF_PIX,
    parameter  int PW    = DEF_PW,
    parameter  int BLK   = DEF_BLK,
    parameter  int RANGE = DEF_RANGE,
    localparam int SADW  = sad_width(PW, BLK),
    localparam int MVW   = mv_width(RANGE),
    localparam int SWA   = sw_addr_width(BLK, RANGE),
    localparam int TBA   = tb_addr_width(BLK, PIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              et_en,
    output logic              ack,
    output logic [SADW-1:0]   min_sad,
    output logic [2*MVW-1:0]  min_mvec,
    output logic [SWA-1:0]    addr_sw,
    input  logic [PIX*PW-1:0] pel_sw,
    output logic [TBA-1:0]    addr_tb,
    input  logic [PIX*PW-1:0] pel_tb
);

    localparam int SWW = BLK + RANGE - 1;
    localparam int WPR = BLK / PIX;
    localparam int TW  = tree_width(PW, PIX);
    localparam int RW  = cnt_width(BLK);
    localparam int CW  = cnt_width(WPR);

    me_state_t state, state_nxt;

    logic [MVW-1:0]  cur_h, cur_w;
    logic [RW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic            et_q;
    logic            done_pend;

    logic            s1_valid, s1_last, s1_first;
    logic [MVW-1:0]  s1_h, s1_w;
    logic            s2_valid, s2_last, s2_first;
    logic [MVW-1:0]  s2_h, s2_w;
    logic [TW-1:0]   s2_sum;

    logic [SADW-1:0] acc;
    logic [SADW-1:0] acc_new;
    logic [TW-1:0]   tree_sum;

    logic            start;
    logic            word_last;
    logic            last_addr;
    logic            cand_end;
    logic            abort;
    logic            s2_final;
    logic            final_evt;
    logic [MVW-1:0]  nxt_h, nxt_w;

    me_sad_tree #(
        .PIX (PIX),
        .PW  (PW)
    ) u_tree (
        .pel_a (pel_sw),
        .pel_b (pel_tb),
        .sad   (tree_sum)
    );

    assign start     = (state == IDLE) && req;
    assign word_last = (cur_row == RW'(BLK-1)) && (cur_col == CW'(WPR-1));
    assign last_addr = word_last && (cur_h == MVW'(RANGE-1)) && (cur_w == MVW'(RANGE-1));
    assign acc_new   = acc + SADW'(s2_sum);
    assign cand_end  = s2_valid && s2_last;
    assign abort     = s2_valid && !s2_last && et_q && !s2_first && (acc_new >= min_sad);
    assign s2_final  = (s2_h == MVW'(RANGE-1)) && (s2_w == MVW'(RANGE-1));
    assign final_evt = (cand_end || abort) && s2_final;
    assign ack       = (state == DONE);

    // Raster successor of the candidate sitting in the accumulate stage,
    // used as the restart point when that candidate is abandoned.
    always_comb begin
        nxt_h = s2_h;
        nxt_w = s2_w + 1'b1;
        if (s2_w == MVW'(RANGE-1)) begin
            nxt_w = '0;
            nxt_h = s2_h + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an abort can pull DRAIN back into RUN when the
    // abandoned candidate is not the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = s2_final ? DRAIN : RUN;
                end else if (last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort && !s2_final) begin
                    state_nxt = RUN;
                end else if (done_pend) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory addresses are only driven while reads are being issued.
    always_comb begin
        addr_sw = '0;
        addr_tb = '0;
        if (state == RUN) begin
            addr_sw = SWA'((32'(cur_h) + 32'(cur_row)) * SWW + 32'(cur_w) + 32'(cur_col) * PIX);
            addr_tb = TBA'(32'(cur_row) * WPR + 32'(cur_col));
        end
    end

    // Address counters, read pipeline tags, accumulator and running minimum.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_h     <= '0;
            cur_w     <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            et_q      <= 1'b0;
            done_pend <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_first  <= 1'b0;
            s1_h      <= '0;
            s1_w      <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_first  <= 1'b0;
            s2_h      <= '0;
            s2_w      <= '0;
            s2_sum    <= '0;
            acc       <= '0;
            min_sad   <= '0;
            min_mvec  <= '0;
        end else if (start) begin
            cur_h     <= '0;
            cur_w     <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            et_q      <= et_en;
            done_pend <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            min_sad   <= '0;
            min_mvec  <= '0;
        end else begin
            s1_valid <= (state == RUN) && !abort;
            s1_last  <= word_last;
            s1_first <= (cur_h == '0) && (cur_w == '0);
            s1_h     <= cur_h;
            s1_w     <= cur_w;

            s2_valid <= s1_valid && !abort;
            s2_last  <= s1_last;
            s2_first <= s1_first;
            s2_h     <= s1_h;
            s2_w     <= s1_w;
            s2_sum   <= tree_sum;

            if (abort) begin
                cur_h   <= nxt_h;
                cur_w   <= nxt_w;
                cur_row <= '0;
                cur_col <= '0;
            end else if (state == RUN) begin
                if (cur_col == CW'(WPR-1)) begin
                    cur_col <= '0;
                    if (cur_row == RW'(BLK-1)) begin
                        cur_row <= '0;
                        if (cur_w == MVW'(RANGE-1)) begin
                            cur_w <= '0;
                            cur_h <= cur_h + 1'b1;
                        end else begin
                            cur_w <= cur_w + 1'b1;
                        end
                    end else begin
                        cur_row <= cur_row + 1'b1;
                    end
                end else begin
                    cur_col <= cur_col + 1'b1;
                end
            end

            if (abort || cand_end) begin
                acc <= '0;
            end else if (s2_valid) begin
                acc <= acc_new;
            end

            if (cand_end && (s2_first || (acc_new < min_sad))) begin
                min_sad  <= acc_new;
                min_mvec <= {s2_h, s2_w};
            end

            done_pend <= done_pend | final_evt;
        end
    end

endmodule

// File: tb/tb_me_sad_search.sv
// Directed bench for the SAD search: a default-size instance for the fixed
// data patterns and a small instance checked against a software search.
module tb_me_sad_search;
    import me_pkg::*;

    localparam int A_SWW = 31;
    localparam int A_LAT = 16*16*16*16/4 + 3;
    localparam int B_SWW = 7;
    localparam int B_LAT = 4*4*4*4/1 + 3;

    localparam int LAT_EXACT = 0;
    localparam int LAT_EARLY = 1;
    localparam int LAT_ANY   = 2;

    typedef struct packed {
        int sad;
        int mv;
        int lat;
        int mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, et_a, ack_a;
    logic [15:0] sad_a;
    logic [7:0]  mv_a;
    logic [9:0]  asw_a;
    logic [31:0] psw_a;
    logic [5:0]  atb_a;
    logic [31:0] ptb_a;
    logic        req_b, et_b, ack_b;
    logic [11:0] sad_b;
    logic [3:0]  mv_b;
    logic [5:0]  asw_b;
    logic [7:0]  psw_b;
    logic [3:0]  atb_b;
    logic [7:0]  ptb_b;

    int          sw_pix [961];
    int          tb_pix [256];
    exp_t        sb_q [$];
    int          sel;
    int          checks;
    int          failures;

    logic        cur_ack;
    logic [31:0] cur_sad, cur_mv, cur_asw, cur_atb;

    always #5 clk = ~clk;

    me_sad_search u_dut_a (
        .clk (clk), .rst (rst), .req (req_a), .et_en (et_a), .ack (ack_a),
        .min_sad (sad_a), .min_mvec (mv_a),
        .addr_sw (asw_a), .pel_sw (psw_a), .addr_tb (atb_a), .pel_tb (ptb_a)
    );

    me_sad_search #(.PIX (1), .PW (8), .BLK (4), .RANGE (4)) u_dut_b (
        .clk (clk), .rst (rst), .req (req_b), .et_en (et_b), .ack (ack_b),
        .min_sad (sad_b), .min_mvec (mv_b),
        .addr_sw (asw_b), .pel_sw (psw_b), .addr_tb (atb_b), .pel_tb (ptb_b)
    );

    function automatic int rd_sw(input int k);
        return (k >= 0 && k < 961) ? sw_pix[k] : 0;
    endfunction

    // Synchronous read memories with one cycle of latency; window reads may
    // start at any pixel.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            psw_a[i*8 +: 8] <= 8'(rd_sw(int'(asw_a) + i));
            ptb_a[i*8 +: 8] <= 8'(tb_pix[int'(atb_a)*4 + i]);
        end
        psw_b <= 8'(rd_sw(int'(asw_b)));
        ptb_b <= 8'(tb_pix[int'(atb_b)]);
    end

    always_comb begin
        if (sel == 0) begin
            cur_ack = ack_a;
            cur_sad = 32'(sad_a);
            cur_mv  = 32'(mv_a);
            cur_asw = 32'(asw_a);
            cur_atb = 32'(atb_a);
        end else begin
            cur_ack = ack_b;
            cur_sad = 32'(sad_b);
            cur_mv  = 32'(mv_b);
            cur_asw = 32'(asw_b);
            cur_atb = 32'(atb_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_req(input logic v);
        if (sel == 0) req_a = v; else req_b = v;
    endtask

    task automatic flip_et();
        if (sel == 0) et_a = ~et_a; else et_b = ~et_b;
    endtask

    task automatic load_embedded();
        for (int k = 0; k < 961; k++) sw_pix[k] = 255;
        for (int k = 0; k < 256; k++) tb_pix[k] = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                sw_pix[(3 + r)*A_SWW + 5 + c] = 0;
    endtask

    task automatic load_const(input int sw_v, input int tb_v);
        for (int k = 0; k < 961; k++) sw_pix[k] = sw_v;
        for (int k = 0; k < 256; k++) tb_pix[k] = tb_v;
    endtask

    task automatic load_random(input int maxv);
        for (int k = 0; k < 49; k++) sw_pix[k] = int'($urandom_range(maxv, 0));
        for (int k = 0; k < 16; k++) tb_pix[k] = int'($urandom_range(maxv, 0));
    endtask

    // Exhaustive software search for the small instance, first minimum wins.
    task automatic model_small(output int best, output int best_mv);
        int s;
        int d;
        best = -1;
        best_mv = 0;
        for (int h = 0; h < 4; h++) begin
            for (int w = 0; w < 4; w++) begin
                s = 0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        d = sw_pix[(h + r)*B_SWW + w + c] - tb_pix[r*4 + c];
                        s += (d < 0) ? -d : d;
                    end
                end
                if (best < 0 || s < best) begin
                    best = s;
                    best_mv = (h << 2) | w;
                end
            end
        end
    endtask

    // Raise the request at a falling edge and record what the search must return.
    task automatic applyStimulus(input int which, input logic et, input int sad,
                                 input int mv, input int lat, input int mode);
        exp_t e;
        sel = which;
        if (which == 0) et_a = et; else et_b = et;
        set_req(1'b1);
        e.sad  = sad;
        e.mv   = mv;
        e.lat  = lat;
        e.mode = mode;
        sb_q.push_back(e);
    endtask

    // The next rising edge samples req in IDLE; wait for ack and compare.
    task automatic checkOutput(input string tag);
        exp_t e;
        int   cyc;
        int   limit;
        e = sb_q.pop_front();
        limit = ((sel == 0) ? A_LAT : B_LAT) + 50;
        cyc = 0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_clr_sad"}, cur_sad, 0);
        check({tag, "_clr_mv"}, cur_mv, 0);
        flip_et();
        while (!cur_ack && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, "_ack"}, {31'd0, cur_ack}, 1);
        check({tag, "_sad"}, cur_sad, e.sad);
        check({tag, "_mv"}, cur_mv, e.mv);
        if (e.mode == LAT_EXACT) check({tag, "_lat"}, cyc, e.lat);
        if (e.mode == LAT_EARLY) check({tag, "_lat_early"}, {31'd0, (cyc < e.lat)}, 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack_hold"}, {31'd0, cur_ack}, 1);
        check({tag, "_sad_hold"}, cur_sad, e.sad);
        set_req(1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack_drop"}, {31'd0, cur_ack}, 0);
        check({tag, "_idle_asw"}, cur_asw, 0);
        check({tag, "_idle_atb"}, cur_atb, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int bs;
        int bm;
        checks = 0;
        failures = 0;
        sel = 0;
        rst = 1'b1;
        req_a = 1'b0; et_a = 1'b0;
        req_b = 1'b0; et_b = 1'b0;
        load_const(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, cur_ack}, 0);
        check("rst_sad", cur_sad, 0);
        check("rst_mv", cur_mv, 0);
        check("rst_asw", cur_asw, 0);
        check("rst_atb", cur_atb, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] embedded template at h=3 w=5");
        load_embedded();
        applyStimulus(0, 1'b0, 0, (3 << 4) | 5, A_LAT, LAT_EXACT);
        checkOutput("emb");

        $display("[TB] all-zero data, first candidate wins the tie");
        load_const(0, 0);
        applyStimulus(0, 1'b0, 0, 0, A_LAT, LAT_EXACT);
        checkOutput("zero");

        $display("[TB] template ones over zero window");
        load_const(0, 1);
        applyStimulus(0, 1'b0, 256, 0, A_LAT, LAT_EXACT);
        checkOutput("ones");

        $display("[TB] embedded template with early termination");
        load_embedded();
        applyStimulus(0, 1'b1, 0, (3 << 4) | 5, A_LAT, LAT_EARLY);
        checkOutput("emb_et");

        $display("[TB] reset 100 cycles into a search");
        applyStimulus(0, 1'b0, 0, (3 << 4) | 5, A_LAT, LAT_EXACT);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ack", {31'd0, cur_ack}, 0);
        check("midrst_sad", cur_sad, 0);
        check("midrst_mv", cur_mv, 0);
        check("midrst_asw", cur_asw, 0);
        check("midrst_atb", cur_atb, 0);
        rst = 1'b0;
        checkOutput("after_rst");

        $display("[TB] small instance against software search");
        for (int run = 0; run < 4; run++) begin
            load_random((run < 2) ? 255 : 7);
            model_small(bs, bm);
            applyStimulus(1, 1'(run & 1), bs, bm, B_LAT, (run & 1) ? LAT_ANY : LAT_EXACT);
            checkOutput($sformatf("small%0d", run));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
